// File: rtl/ball_motion_pkg.sv
// Shared types and constants for the ball motion block: pixel/field widths,
// playfield geometry, direction encoding and the ball FSM state enum.
package ball_motion_pkg;

  localparam int PIXELX_BITS    = 10;
  localparam int PIXELY_BITS    = 9;
  localparam int PLAT_HF_BITS   = 6;
  localparam int STEP_BITS      = 3;
  localparam int BALL_SIZE_BITS = 4;

  localparam int SCREEN_W_DEF   = 640;
  localparam int SCREEN_H_DEF   = 480;
  localparam int WALL_THICKNESS = 16;

  // Extended widths keep every compare free of wrap-around.
  localparam int XE = PIXELX_BITS + 1;
  localparam int YE = PIXELY_BITS + 1;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [1:0] {
    ST_HELD     = 2'd0,
    ST_FLY_IDLE = 2'd1,
    ST_FLY_STEP = 2'd2,
    ST_DEAD     = 2'd3
  } ball_state_e;

  function automatic logic [XE-1:0] abs_diff_x(input logic [PIXELX_BITS-1:0] a,
                                               input logic [PIXELX_BITS-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/ball_motion_edge_check.sv
// Combinational wall / platform / bottom tests on a candidate ball position.
module ball_edge_check
  import ball_motion_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int WALL_T   = WALL_THICKNESS
) (
  input  logic [PIXELX_BITS-1:0]    x_i,
  input  logic [PIXELY_BITS-1:0]    y_i,
  input  logic [BALL_SIZE_BITS-1:0] size_i,
  input  logic [PIXELX_BITS-1:0]    plat_x_i,
  input  logic [PIXELY_BITS-1:0]    plat_y_i,
  input  logic [PLAT_HF_BITS-1:0]   plat_size_i,
  output logic                      left_o,
  output logic                      right_o,
  output logic                      top_o,
  output logic                      plat_o,
  output logic                      bottom_o
);

  localparam logic [XE-1:0] X_WALL  = XE'(WALL_T);
  localparam logic [XE-1:0] X_RIGHT = XE'(SCREEN_W - WALL_T - 1);
  localparam logic [YE-1:0] Y_WALL  = YE'(WALL_T);
  localparam logic [YE-1:0] Y_BOT   = YE'(SCREEN_H);

  logic [XE-1:0] x_e;
  logic [XE-1:0] xs_e;
  logic [YE-1:0] y_e;
  logic [YE-1:0] ys_e;

  assign x_e  = XE'(x_i);
  assign xs_e = XE'(size_i);
  assign y_e  = YE'(y_i);
  assign ys_e = YE'(size_i);

  // Subtractions are rearranged as additions on the other side so nothing underflows.
  assign left_o   = x_e <= X_WALL + xs_e;
  assign right_o  = x_e + xs_e >= X_RIGHT;
  assign top_o    = y_e <= Y_WALL + ys_e;
  assign bottom_o = y_e >= Y_BOT + ys_e;
  assign plat_o   = (y_e + ys_e + YE'(1) == YE'(plat_y_i)) &&
                    (abs_diff_x(x_i, plat_x_i) <= XE'(plat_size_i));

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction owner: steps the ball speedstep pixels per frame tick,
// reflects off walls, platform and brick flips, holds on grab, flags life loss.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int WALL_T   = WALL_THICKNESS,
  parameter int HOLD_OFS = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_game_start,
  input  logic                      i_cal_frame,
  input  logic                      i_launch,
  input  logic                      i_grab,
  input  logic [PIXELX_BITS-1:0]    i_platX,
  input  logic [PIXELY_BITS-1:0]    i_platY,
  input  logic [PLAT_HF_BITS-1:0]   i_plat_size,
  input  logic [STEP_BITS-1:0]      i_speedstep,
  input  logic [BALL_SIZE_BITS-1:0] i_ball_size,
  input  logic                      i_flip_x,
  input  logic                      i_flip_y,
  output logic [PIXELX_BITS-1:0]    o_ballX,
  output logic [PIXELY_BITS-1:0]    o_ballY,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_life_lost,
  output logic [1:0]                o_state
);

  localparam logic [PIXELX_BITS-1:0] X_RST   = PIXELX_BITS'(SCREEN_W / 2);
  localparam logic [PIXELY_BITS-1:0] Y_RST   = PIXELY_BITS'(SCREEN_H - 40 - 6);
  localparam logic signed [XE-1:0]   OFS_RST = XE'(HOLD_OFS);

  ball_state_e             state_q;
  logic [PIXELX_BITS-1:0]  x_q;
  logic [PIXELY_BITS-1:0]  y_q;
  logic                    dx_q, dy_q, fx_q, fy_q;
  logic signed [XE-1:0]    ofs_q;
  logic [STEP_BITS-1:0]    cnt_q, spd_q;
  logic                    busy_q, done_q, lost_q;

  logic                    dx_eff, dy_eff, ndx, ndy;
  logic [PIXELX_BITS-1:0]  step_x, held_x;
  logic [PIXELY_BITS-1:0]  step_y, held_y;
  logic signed [XE-1:0]    held_sum, grab_ofs;
  logic                    hit_left, hit_right, hit_top, plat_zone, hit_bottom;
  logic                    plat_hit, last_step;

  ball_edge_check #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .WALL_T   (WALL_T)
  ) u_edge (
    .x_i         (step_x),
    .y_i         (step_y),
    .size_i      (i_ball_size),
    .plat_x_i    (i_platX),
    .plat_y_i    (i_platY),
    .plat_size_i (i_plat_size),
    .left_o      (hit_left),
    .right_o     (hit_right),
    .top_o       (hit_top),
    .plat_o      (plat_zone),
    .bottom_o    (hit_bottom)
  );

  // A pending flip reverses the direction before the move; a wall hit then overrides it.
  always_comb begin
    dx_eff    = dx_q ^ fx_q;
    dy_eff    = dy_q ^ fy_q;
    step_x    = dx_eff ? x_q + PIXELX_BITS'(1) : x_q - PIXELX_BITS'(1);
    step_y    = dy_eff ? y_q + PIXELY_BITS'(1) : y_q - PIXELY_BITS'(1);
    ndx       = dx_eff;
    if (hit_left)  ndx = DIR_POS;
    if (hit_right) ndx = DIR_NEG;
    ndy       = dy_eff;
    if (hit_top)   ndy = DIR_POS;
    plat_hit  = (ndy == DIR_POS) && plat_zone;
    if (plat_hit)  ndy = DIR_NEG;
    held_sum  = $signed({1'b0, i_platX}) + ofs_q;
    held_x    = held_sum[PIXELX_BITS-1:0];
    held_y    = i_platY - PIXELY_BITS'(i_ball_size) - PIXELY_BITS'(1);
    grab_ofs  = $signed({1'b0, step_x}) - $signed({1'b0, i_platX});
    last_step = ({1'b0, cnt_q} + (STEP_BITS+1)'(1)) >= {1'b0, spd_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HELD;
      x_q     <= X_RST;
      y_q     <= Y_RST;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      ofs_q   <= OFS_RST;
      cnt_q   <= '0;
      spd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lost_q <= 1'b0;
      if (i_game_start) begin
        state_q <= ST_HELD;
        ofs_q   <= OFS_RST;
        dx_q    <= DIR_POS;
        dy_q    <= DIR_NEG;
        fx_q    <= 1'b0;
        fy_q    <= 1'b0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_HELD: begin
            if (i_cal_frame) begin
              x_q <= held_x;
              y_q <= held_y;
            end
            if (i_launch) state_q <= ST_FLY_IDLE;
          end
          ST_FLY_IDLE: begin
            fx_q <= fx_q | i_flip_x;
            fy_q <= fy_q | i_flip_y;
            if (i_cal_frame) begin
              state_q <= ST_FLY_STEP;
              spd_q   <= i_speedstep;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_FLY_STEP: begin
            x_q   <= step_x;
            y_q   <= step_y;
            dx_q  <= ndx;
            dy_q  <= ndy;
            // Pending flips were consumed by this step; a flip arriving now waits for the next.
            fx_q  <= i_flip_x;
            fy_q  <= i_flip_y;
            cnt_q <= cnt_q + STEP_BITS'(1);
            if (plat_hit && i_grab) begin
              ofs_q   <= grab_ofs;
              state_q <= ST_HELD;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (hit_bottom) begin
              state_q <= ST_DEAD;
              lost_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (last_step) begin
              state_q <= ST_FLY_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ballX      = x_q;
  assign o_ballY      = y_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_life_lost  = lost_q;
  assign o_state      = state_q;

endmodule
